// File: rtl/return_stack_sequencer_pkg.sv
// Shared encodings for the control-transfer path: branch types and sequencer FSM states.
package return_stack_sequencer_pkg;

    typedef enum logic [1:0] {
        BR_UNCOND = 2'b00,
        BR_COND   = 2'b01,
        BR_SUB    = 2'b10,
        BR_RET    = 2'b11
    } br_type_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_REDIRECT = 1'b1
    } state_e;

endpackage

// File: rtl/return_stack_sequencer_if.sv
// Decode/fetch-facing bundle of the return stack sequencer; the master side is decode plus fetch.
interface return_stack_sequencer_if #(
    parameter int DEPTH = 4,
    parameter int AW    = 8
);
    localparam int DW = $clog2(DEPTH) + 1;

    logic          br_valid;
    logic          br_ready;
    logic [1:0]    br_type;
    logic          brx;
    logic          zero;
    logic          negative;
    logic [AW-1:0] ea;
    logic [AW-1:0] pc_inc;
    logic          redirect_valid;
    logic [AW-1:0] redirect_pc;
    logic          fetch_ack;
    logic [DW-1:0] depth;
    logic          ovf;
    logic          unf;
    logic          err_clr;

    modport master (
        output br_valid, br_type, brx, zero, negative, ea, pc_inc, fetch_ack, err_clr,
        input  br_ready, redirect_valid, redirect_pc, depth, ovf, unf
    );

    modport slave (
        input  br_valid, br_type, brx, zero, negative, ea, pc_inc, fetch_ack, err_clr,
        output br_ready, redirect_valid, redirect_pc, depth, ovf, unf
    );

endinterface

// File: rtl/return_stack_sequencer_ras_stack.sv
// Return-address LIFO indexed by occupancy; pushes while full and pops while empty are ignored.
module ras_stack #(
    parameter int DEPTH = 4,
    parameter int AW    = 8,
    localparam int IW   = $clog2(DEPTH),
    localparam int DW   = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          resetn,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic [AW-1:0] data_i,
    output logic [AW-1:0] top_o,
    output logic [DW-1:0] depth_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [AW-1:0] stack_q [DEPTH];
    logic [DW-1:0] depth_q;
    logic [DW-1:0] depth_d;
    logic [IW-1:0] wrIdx;
    logic [IW-1:0] rdIdx;

    // Low index bits wrap to 0 when full, so rdIdx still lands on the last entry.
    assign wrIdx   = depth_q[IW-1:0];
    assign rdIdx   = wrIdx - IW'(1);
    assign full_o  = (depth_q == DW'(DEPTH));
    assign empty_o = (depth_q == '0);
    assign top_o   = stack_q[rdIdx];
    assign depth_o = depth_q;

    always_comb begin
        depth_d = depth_q;
        if (push_i && !full_o) begin
            depth_d = depth_q + DW'(1);
        end else if (pop_i && !empty_o) begin
            depth_d = depth_q - DW'(1);
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            depth_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                stack_q[i] <= '0;
            end
        end else begin
            depth_q <= depth_d;
            if (push_i && !full_o) begin
                stack_q[wrIdx] <= data_i;
            end
        end
    end

endmodule

// File: rtl/return_stack_sequencer.sv
// Resolves BR/BR.C/BR.SUB/RET into a registered PC redirect held until fetch acknowledges it.
module return_stack_sequencer
    import return_stack_sequencer_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int AW    = 8
) (
    input logic                    clock,
    input logic                    resetn,
    return_stack_sequencer_if.slave bus
);

    localparam int DW = $clog2(DEPTH) + 1;

    state_e        state_q;
    logic          redirect_valid_q;
    logic [AW-1:0] redirect_pc_q;
    logic          ovf_q;
    logic          unf_q;

    br_type_e      brType;
    logic          accept;
    logic          cond;
    logic          push;
    logic          pop;
    logic          stackFull;
    logic          stackEmpty;
    logic [AW-1:0] stackTop;
    logic [DW-1:0] stackDepth;

    assign brType = br_type_e'(bus.br_type);
    assign accept = bus.br_valid && bus.br_ready;
    assign cond   = bus.brx ? bus.zero : bus.negative;
    assign push   = accept && (brType == BR_SUB) && !stackFull;
    assign pop    = accept && (brType == BR_RET) && !stackEmpty;

    ras_stack #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_stack (
        .clock   (clock),
        .resetn  (resetn),
        .push_i  (push),
        .pop_i   (pop),
        .data_i  (bus.pc_inc),
        .top_o   (stackTop),
        .depth_o (stackDepth),
        .full_o  (stackFull),
        .empty_o (stackEmpty)
    );

    assign bus.br_ready       = resetn && (state_q == ST_IDLE);
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;
    assign bus.depth          = stackDepth;
    assign bus.ovf            = ovf_q;
    assign bus.unf            = unf_q;

    // err_clr is applied first so a fresh error in the same cycle overrides it.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state_q          <= ST_IDLE;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            ovf_q            <= 1'b0;
            unf_q            <= 1'b0;
        end else begin
            if (bus.err_clr) begin
                ovf_q <= 1'b0;
                unf_q <= 1'b0;
            end
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        case (brType)
                            BR_UNCOND: begin
                                redirect_pc_q    <= bus.ea;
                                redirect_valid_q <= 1'b1;
                                state_q          <= ST_REDIRECT;
                            end
                            BR_COND: begin
                                if (cond) begin
                                    redirect_pc_q    <= bus.ea;
                                    redirect_valid_q <= 1'b1;
                                    state_q          <= ST_REDIRECT;
                                end
                            end
                            BR_SUB: begin
                                if (stackFull) begin
                                    ovf_q <= 1'b1;
                                end
                                redirect_pc_q    <= bus.ea;
                                redirect_valid_q <= 1'b1;
                                state_q          <= ST_REDIRECT;
                            end
                            BR_RET: begin
                                if (stackEmpty) begin
                                    unf_q         <= 1'b1;
                                    redirect_pc_q <= '0;
                                end else begin
                                    redirect_pc_q <= stackTop;
                                end
                                redirect_valid_q <= 1'b1;
                                state_q          <= ST_REDIRECT;
                            end
                            default: ;
                        endcase
                    end
                end
                ST_REDIRECT: begin
                    if (bus.fetch_ack) begin
                        redirect_valid_q <= 1'b0;
                        state_q          <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/return_stack_sequencer.md
Name: return_stack_sequencer

Overview:
Sequences all control-transfer instructions for the single-cycle core. It resolves BR, BR.C, BR.SUB and RET, and keeps a hardware return-address stack so that nested subroutine calls are supported. Each taken branch is turned into a registered PC-redirect request to fetch, which fetch acknowledges with a handshake. The block sits between decode/ALU flags and the PC register.

Parameters:
DEPTH, 4, number of return-address stack entries (power of 2, 2..16)
AW, 8, address width of PC and effective address

Ports:
clock  in  1  system clock, rising edge
resetn  in  1  asynchronous active-low reset
br_valid  in  1  decode presents a control-transfer instruction
br_ready  out  1  sequencer can accept an instruction
br_type  in  2  00 BR, 01 BR.C, 10 BR.SUB, 11 RET
brx  in  1  condition select: 1 = zero flag, 0 = negative flag
zero  in  1  ALU zero flag
negative  in  1  ALU negative flag
ea  in  AW  branch target (effective address)
pc_inc  in  AW  PC+1 of the branch instruction
redirect_valid  out  1  registered request to load the PC
redirect_pc  out  AW  target PC, stable while redirect_valid=1
fetch_ack  in  1  fetch has taken the redirect
depth  out  clog2(DEPTH)+1  current stack occupancy
ovf  out  1  sticky: push attempted while full
unf  out  1  sticky: pop attempted while empty
err_clr  in  1  synchronous clear of ovf/unf

Behaviour:
- Reset (async, resetn=0):
  - state=IDLE; redirect_valid=0; redirect_pc=0; depth=0; ovf=0; unf=0; all stack entries=0.
  - br_ready=0 while resetn=0.
- FSM states: IDLE and REDIRECT. br_ready=1 only in IDLE.
- Accept means br_valid & br_ready at a rising edge.
- Condition: cond = brx ? zero : negative, sampled in the accept cycle.
- On accept in IDLE:
  - BR: redirect_pc<=ea; go to REDIRECT.
  - BR.C, cond=1: as BR.
  - BR.C, cond=0: no redirect; stay IDLE; br_ready remains 1 (back-to-back accept allowed).
  - BR.SUB, depth<DEPTH: push pc_inc at stack[depth]; depth+1; redirect_pc<=ea; go to REDIRECT.
  - BR.SUB, depth==DEPTH: no push; ovf<=1; depth unchanged; the redirect to ea still occurs.
  - RET, depth>0: redirect_pc<=stack[depth-1]; depth-1; go to REDIRECT.
  - RET, depth==0: unf<=1; redirect_pc<=0; go to REDIRECT.
- REDIRECT:
  - redirect_valid=1 and redirect_pc held constant.
  - On fetch_ack=1: next cycle redirect_valid=0, state=IDLE.
  - Minimum one-cycle redirect pulse; br_valid is ignored while in REDIRECT.
- Latency: accept edge -> redirect_valid high on the next cycle. fetch_ack in that first cycle -> low again one cycle later. Earliest next accept is the cycle after return to IDLE.
- err_clr=1 clears ovf/unf at the edge. If err_clr and a new error occur in the same edge, the error wins (flag=1).
- fetch_ack in IDLE is ignored.
- Stack is LIFO indexed by depth; no wrap-around. Full and empty are handled only via ovf/unf as above.
- Reset asserted mid-REDIRECT immediately drops redirect_valid and empties the stack.
- All outputs are registered except br_ready, which decodes from state and resetn.

Decomposition:
- Shared package holds:
  - br_type encodings BR_UNCOND=2'b00, BR_COND=2'b01, BR_SUB=2'b10, BR_RET=2'b11 (shared with decode and the link register path).
  - FSM state encodings ST_IDLE, ST_REDIRECT.
- One sub-module: ras_stack (DEPTH x AW LIFO with push/pop/full/empty/top and async reset). The FSM and condition logic stay in the top.

Test Plan:
1. Reset, then BR ea=0x40 -> next cycle redirect_valid=1, redirect_pc=0x40. Hold fetch_ack=0 for 3 cycles -> redirect_pc stays 0x40. After fetch_ack -> idle, br_ready=1.
2. BR.C brx=1 zero=0 ea=0x20 pc_inc=0x11 -> no redirect, br_ready=1 every cycle. Then brx=0 negative=1 -> redirect_pc=0x20.
3. BR.SUB ea=0x80 pc_inc=0x05, then BR.SUB ea=0x90 pc_inc=0x81 -> depth=2. RET -> redirect_pc=0x81. RET -> redirect_pc=0x05, depth=0.
4. DEPTH=4: five BR.SUB with pc_inc=0x01..0x05 -> ovf=1, depth=4. Four RETs -> 0x04,0x03,0x02,0x01. Fifth RET -> unf=1, redirect_pc=0x00.
5. err_clr pulse with ovf=unf=1 -> both 0. err_clr coincident with a RET on an empty stack -> unf=1.
6. Assert resetn=0 during REDIRECT with depth=3 -> redirect_valid=0 and depth=0 immediately (async). After release, a RET sets unf=1.
